// File: rtl/sio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sio_pkg
// Purpose  : State encodings and framing constants shared by the SIO engine.
// Revision : 1.0 - initial release
// ============================================================================
package sio_pkg;

  typedef logic [1:0] sio_state_t;

  localparam sio_state_t IDLE  = 2'd0;
  localparam sio_state_t START = 2'd1;
  localparam sio_state_t DATA  = 2'd2;
  localparam sio_state_t STOP  = 2'd3;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

endpackage
`default_nettype wire

// File: rtl/sio_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : sio_bit_timer
// Purpose  : ce-gated, self-reloading down-counter with a one-clk tick output.
// Revision : 1.0 - initial release
// ============================================================================
module sio_bit_timer #(
  parameter int CNT_W  = 12,
  parameter int PERIOD = 108
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tick
);

  localparam logic [CNT_W-1:0] c_period = CNT_W'(PERIOD);

  logic [CNT_W-1:0] r_cnt;

  // A value of N fires the tick on the Nth ce after the load, then every PERIOD ce.
  assign tick = ce && !load && (r_cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (ce) begin
      if (r_cnt < CNT_W'(2)) begin
        r_cnt <= c_period;
      end else begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sio_uart_core.sv
`default_nettype none
// ============================================================================
// Module   : sio_uart_core
// Purpose  : 8N1 LSB-first serialiser/deserialiser timed by the CPU clock-enable.
// Revision : 1.0 - initial release
// ============================================================================
module sio_uart_core
  import sio_pkg::*;
#(
  parameter int BIT_DIV = 108,
  parameter int CNT_W   = 12
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       rx,
  output logic       tx,
  input  logic [7:0] tx_data,
  input  logic       tx_we,
  output logic       tx_empty,
  output logic [7:0] rx_data,
  output logic       rx_full,
  input  logic       rx_ack,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [CNT_W-1:0] c_bit_div  = CNT_W'(BIT_DIV);
  localparam logic [CNT_W-1:0] c_half_div = CNT_W'(BIT_DIV / 2);
  localparam logic [2:0]       c_last_bit = 3'(DATA_BITS - 1);

  // Reset asserts asynchronously, releases on a clk edge.
  logic [1:0] r_rst_pipe;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_pipe <= 2'b00;
    end else begin
      r_rst_pipe <= {r_rst_pipe[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_pipe[1];

  // ---------------------------------------------------------------- transmit
  sio_state_t r_tx_state, w_tx_state_nxt;
  logic [7:0] r_tx_shift, w_tx_shift_nxt;
  logic [2:0] r_tx_bit, w_tx_bit_nxt;
  logic       r_tx, w_tx_nxt;
  logic       w_tx_load, w_tx_tick;

  sio_bit_timer #(
    .CNT_W  (CNT_W),
    .PERIOD (BIT_DIV)
  ) u_tx_timer (
    .clk      (clk),
    .reset_n  (w_rst_n),
    .ce       (ce),
    .load     (w_tx_load),
    .load_val (c_bit_div),
    .tick     (w_tx_tick)
  );

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_tx_state <= IDLE;
      r_tx_shift <= '0;
      r_tx_bit   <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx       <= w_tx_nxt;
    end
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_load      = 1'b0;
    case (r_tx_state)
      IDLE: begin
        if (tx_we) begin
          w_tx_load      = 1'b1;
          w_tx_shift_nxt = tx_data;
          w_tx_state_nxt = START;
        end
      end
      START: begin
        if (w_tx_tick) begin
          w_tx_state_nxt = DATA;
          w_tx_bit_nxt   = '0;
        end
      end
      DATA: begin
        if (w_tx_tick) begin
          w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
          w_tx_bit_nxt   = r_tx_bit + 3'd1;
          if (r_tx_bit == c_last_bit) begin
            w_tx_state_nxt = STOP;
          end
        end
      end
      STOP: begin
        if (w_tx_tick) begin
          w_tx_state_nxt = IDLE;
        end
      end
      default: w_tx_state_nxt = IDLE;
    endcase

    // Line level is registered from the next state so tx never glitches.
    case (w_tx_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_tx_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  assign tx       = r_tx;
  assign tx_empty = (r_tx_state == IDLE);

  // ----------------------------------------------------------------- receive
  logic       r_rx_meta, r_rx_sync, r_rx_prev;
  sio_state_t r_rx_state, w_rx_state_nxt;
  logic [7:0] r_rx_shift, w_rx_shift_nxt;
  logic [2:0] r_rx_bit, w_rx_bit_nxt;
  logic       w_rx_load, w_rx_tick, w_rx_fall, w_rx_done, w_rx_busy;
  logic [7:0] r_rx_data;
  logic       r_rx_full, r_frame_err, r_overrun;

  sio_bit_timer #(
    .CNT_W  (CNT_W),
    .PERIOD (BIT_DIV)
  ) u_rx_timer (
    .clk      (clk),
    .reset_n  (w_rst_n),
    .ce       (ce),
    .load     (w_rx_load),
    .load_val (c_half_div),
    .tick     (w_rx_tick)
  );

  // r_rx_prev holds the line as seen at the previous ce tick.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      if (ce) begin
        r_rx_prev <= r_rx_sync;
      end
    end
  end

  assign w_rx_fall = ce && r_rx_prev && !r_rx_sync;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rx_state <= IDLE;
      r_rx_shift <= '0;
      r_rx_bit   <= '0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
    end
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_load      = 1'b0;
    w_rx_done      = 1'b0;
    case (r_rx_state)
      IDLE: begin
        if (w_rx_fall) begin
          w_rx_load      = 1'b1;
          w_rx_state_nxt = START;
        end
      end
      START: begin
        if (w_rx_tick) begin
          if (r_rx_sync) begin
            w_rx_state_nxt = IDLE;
          end else begin
            w_rx_state_nxt = DATA;
            w_rx_bit_nxt   = '0;
          end
        end
      end
      DATA: begin
        if (w_rx_tick) begin
          w_rx_shift_nxt = {r_rx_sync, r_rx_shift[7:1]};
          w_rx_bit_nxt   = r_rx_bit + 3'd1;
          if (r_rx_bit == c_last_bit) begin
            w_rx_state_nxt = STOP;
          end
        end
      end
      STOP: begin
        if (w_rx_tick) begin
          w_rx_done      = 1'b1;
          w_rx_state_nxt = IDLE;
        end
      end
      default: w_rx_state_nxt = IDLE;
    endcase
  end

  // An ack arriving with a completion frees the holding register for the new byte.
  assign w_rx_busy = r_rx_full && !rx_ack;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rx_data   <= '0;
      r_rx_full   <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_rx_done && !w_rx_busy) begin
      r_rx_data   <= r_rx_shift;
      r_frame_err <= !r_rx_sync;
      r_rx_full   <= 1'b1;
      r_overrun   <= 1'b0;
    end else if (w_rx_done) begin
      r_overrun   <= 1'b1;
    end else if (rx_ack) begin
      r_rx_full   <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_full   = r_rx_full;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sio_uart_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_sio_uart_core
// Purpose  : Bench for sio_uart_core: tick-count reference model plus directed literals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sio_uart_core;
  import sio_pkg::*;

  localparam int BD          = 4;
  localparam int FRAME_TICKS = FRAME_BITS * BD;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ce = 1'b1;
  logic       rx = 1'b1;
  logic       tx, tx_empty, rx_full, frame_err, overrun;
  logic       tx_we = 1'b0;
  logic       rx_ack = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  int         ce_mode = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  sio_uart_core #(
    .BIT_DIV (BD),
    .CNT_W   (12)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce        (ce),
    .rx        (rx),
    .tx        (tx),
    .tx_data   (tx_data),
    .tx_we     (tx_we),
    .tx_empty  (tx_empty),
    .rx_data   (rx_data),
    .rx_full   (rx_full),
    .rx_ack    (rx_ack),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // ce pattern for the coming edge: 0 = always on, 1 = toggling, 2 = random
  always @(posedge clk) begin
    #1;
    case (ce_mode)
      1:       ce = ~ce;
      2:       ce = 1'($urandom_range(0, 1));
      default: ce = 1'b1;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------ reference model
  // TX: frame position is (ce ticks since accept) / BD; bit 0 start, 1..8 data, 9 stop.
  // RX: after a falling line edge seen on a ce tick, sample at ticks BD/2 + n*BD.
  bit         m_tx_busy = 0;
  int         m_tx_ticks = 0;
  logic [7:0] m_tx_byte = 8'h00;
  logic       m_s1 = 1'b1, m_s2 = 1'b1, m_prev = 1'b1;
  bit         m_rx_busy = 0;
  int         m_rx_cnt = 0;
  logic [7:0] m_rx_sh = 8'h00;
  logic [7:0] m_rx_data = 8'h00;
  logic       m_full = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;

  task automatic model_reset();
    m_tx_busy = 0; m_tx_ticks = 0;
    m_s1 = 1'b1; m_s2 = 1'b1; m_prev = 1'b1;
    m_rx_busy = 0; m_rx_cnt = 0;
    m_rx_data = 8'h00; m_full = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_step();
    bit   done;
    logic stop_s;
    bit   fall;
    int   n;
    if (!m_tx_busy) begin
      if (tx_we) begin
        m_tx_busy = 1; m_tx_byte = tx_data; m_tx_ticks = 0;
      end
    end else if (ce) begin
      m_tx_ticks++;
      if (m_tx_ticks == FRAME_TICKS) m_tx_busy = 0;
    end

    done = 0; stop_s = 1'b1;
    fall = ce && m_prev && !m_s2;
    if (!m_rx_busy) begin
      if (fall) begin
        m_rx_busy = 1; m_rx_cnt = 0;
      end
    end else if (ce) begin
      m_rx_cnt++;
      if (m_rx_cnt >= BD / 2 && (m_rx_cnt - BD / 2) % BD == 0) begin
        n = (m_rx_cnt - BD / 2) / BD;
        if (n == 0) begin
          if (m_s2) m_rx_busy = 0;
        end else if (n <= DATA_BITS) begin
          m_rx_sh[n-1] = m_s2;
        end else begin
          done = 1; stop_s = m_s2; m_rx_busy = 0;
        end
      end
    end

    if (done && (!m_full || rx_ack)) begin
      m_rx_data = m_rx_sh; m_ferr = !stop_s; m_full = 1'b1; m_ovr = 1'b0;
    end else if (done) begin
      m_ovr = 1'b1;
    end else if (rx_ack) begin
      m_full = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    end

    if (ce) m_prev = m_s2;
    m_s2 = m_s1;
    m_s1 = rx;
  endtask

  function automatic logic exp_tx();
    int idx;
    if (!m_tx_busy) return 1'b1;
    idx = m_tx_ticks / BD;
    if (idx == 0) return 1'b0;
    if (idx <= DATA_BITS) return m_tx_byte[idx-1];
    return 1'b1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else          model_step();
  end

  always @(negedge clk) begin
    chk("tx", tx, exp_tx());
    chk("tx_empty", tx_empty, !m_tx_busy);
    chk("rx_full", rx_full, m_full);
    chk("rx_data", rx_data, m_rx_data);
    chk("frame_err", frame_err, m_ferr);
    chk("overrun", overrun, m_ovr);
  end

  // ---------------------------------------------------------- stimulus
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop, input int cpb);
    rx = 1'b0;
    step(cpb);
    for (int i = 0; i < DATA_BITS; i++) begin
      rx = b[i];
      step(cpb);
    end
    rx = stop;
    step(cpb);
    rx = 1'b1;
  endtask

  task automatic wait_full(input int max_clk);
    int n = 0;
    while (rx_full !== 1'b1 && n < max_clk) begin
      step(1);
      n++;
    end
    chk("rx_full_wait", rx_full, 1'b1);
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    step(1);
    rx_ack = 1'b0;
  endtask

  task automatic tx_frame(input logic [7:0] b, input int exp_len);
    int         len = 0;
    int         guard = 0;
    logic [9:0] seq = '0;
    if (ce_mode == 1) begin
      while (ce !== 1'b1 && guard < 4) begin
        step(1);
        guard++;
      end
    end
    tx_data = b;
    tx_we   = 1'b1;
    step(1);
    tx_we   = 1'b0;
    while (tx_empty === 1'b0 && len < 1000) begin
      if (exp_len == FRAME_TICKS && len % BD == BD / 2) seq[len/BD] = tx;
      step(1);
      len++;
    end
    chk("tx_frame_len", len, exp_len);
    if (exp_len == FRAME_TICKS) chk("tx_frame_bits", seq, {1'b1, b, 1'b0});
  endtask

  task automatic random_phase(input int mode, input int cpb, input int n_tx, input int n_rx);
    logic fin = 1'b0;
    ce_mode = mode;
    fork
      begin
        fork
          for (int i = 0; i < n_tx; i++) begin
            step($urandom_range(0, 20));
            tx_data = 8'($urandom);
            tx_we   = 1'b1;
            step(1);
            tx_we   = 1'b0;
          end
          for (int j = 0; j < n_rx; j++) begin
            step($urandom_range(0, 30));
            if ($urandom_range(0, 7) == 0) begin
              rx = 1'b0;
              step(1);
              rx = 1'b1;
            end else begin
              drive_rx(8'($urandom), ($urandom_range(0, 3) != 0), cpb);
            end
          end
        join
        fin = 1'b1;
      end
      while (!fin) begin
        rx_ack = ($urandom_range(0, 11) == 0);
        step(1);
      end
    join
    rx_ack  = 1'b0;
    ce_mode = 0;
    step(FRAME_TICKS * 3);
  endtask

  initial begin
    #900000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    step(3);
    chk("reset_tx", tx, 1'b1);
    chk("reset_tx_empty", tx_empty, 1'b1);
    chk("reset_rx_full", rx_full, 1'b0);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_frame_err", frame_err, 1'b0);
    chk("reset_overrun", overrun, 1'b0);
    reset_n = 1'b1;
    step(5);

    tx_frame(8'h55, 40);

    drive_rx(8'hA3, 1'b1, BD);
    wait_full(8);
    chk("rx_a3_data", rx_data, 8'hA3);
    chk("rx_a3_ferr", frame_err, 1'b0);
    do_ack();
    chk("rx_a3_ack_full", rx_full, 1'b0);

    drive_rx(8'h3C, 1'b0, BD);
    wait_full(8);
    chk("ferr_data", rx_data, 8'h3C);
    chk("ferr_flag", frame_err, 1'b1);
    do_ack();
    chk("ferr_ack_full", rx_full, 1'b0);
    chk("ferr_ack_flag", frame_err, 1'b0);
    step(4);

    drive_rx(8'h11, 1'b1, BD);
    wait_full(8);
    drive_rx(8'h22, 1'b1, BD);
    step(8);
    chk("ovr_data", rx_data, 8'h11);
    chk("ovr_flag", overrun, 1'b1);
    chk("ovr_full", rx_full, 1'b1);
    do_ack();
    chk("ovr_ack_full", rx_full, 1'b0);
    chk("ovr_ack_flag", overrun, 1'b0);

    rx = 1'b0;
    step(1);
    rx = 1'b1;
    step(3 * BD);
    chk("glitch_rx_full", rx_full, 1'b0);

    ce_mode = 1;
    tx_frame(8'h55, 80);
    ce_mode = 0;
    step(2);

    drive_rx(8'h5A, 1'b1, BD);
    wait_full(8);
    tx_data = 8'hC3;
    tx_we   = 1'b1;
    step(1);
    tx_we   = 1'b0;
    fork
      drive_rx(8'h96, 1'b1, BD);
      begin
        step(18);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_tx", tx, 1'b1);
        chk("rst_mid_tx_empty", tx_empty, 1'b1);
        chk("rst_mid_rx_full", rx_full, 1'b0);
      end
    join
    step(3);
    reset_n = 1'b1;
    step(5);
    tx_frame(8'hC3, 40);
    drive_rx(8'h96, 1'b1, BD);
    wait_full(8);
    chk("post_rst_rx_data", rx_data, 8'h96);
    do_ack();

    random_phase(2, 2 * BD, 25, 15);
    random_phase(0, BD, 25, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
